trace_reader: RTL and testbench



---
 rtl/trace_reader.sv | 177 +++++++++++++++++
 tb/tb_trace_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_reader.sv
// Streams bytes from the capture BRAM to the UART transmitter, one byte in flight at a time.
// Define TRACE_CHECKSUM_EN to append an 8-bit sum of the data bytes after the last data byte.
module trace_reader #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    input  logic              uart_tx_ready,
    output logic              uart_tx_enable,
    output logic [DATA_W-1:0] uart_data_to_tx
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        ACK,
        FINISH
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] raddr_reg, raddr_next;
    logic [LEN_W-1:0]  remaining_reg, remaining_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              en_reg, en_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [LEN_W-1:0]  clamped_len;
    logic              start_ok;

`ifdef TRACE_CHECKSUM_EN
    logic [DATA_W-1:0] sum_reg, sum_next;
    logic              csum_reg, csum_next;
`endif

    always_comb begin
        clamped_len = (length > MAX_LEN_V) ? MAX_LEN_V : length;
        // done pulses while already back in IDLE; a start in that cycle is dropped
        start_ok    = start && !done_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            raddr_reg     <= '0;
            remaining_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            en_reg        <= 1'b0;
            data_reg      <= '0;
`ifdef TRACE_CHECKSUM_EN
            sum_reg       <= '0;
            csum_reg      <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            raddr_reg     <= raddr_next;
            remaining_reg <= remaining_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            en_reg        <= en_next;
            data_reg      <= data_next;
`ifdef TRACE_CHECKSUM_EN
            sum_reg       <= sum_next;
            csum_reg      <= csum_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        raddr_next     = raddr_reg;
        remaining_next = remaining_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        en_next        = 1'b0;
        data_next      = data_reg;
`ifdef TRACE_CHECKSUM_EN
        sum_next       = sum_reg;
        csum_next      = csum_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    raddr_next     = start_addr;
                    remaining_next = clamped_len;
                    busy_next      = 1'b1;
`ifdef TRACE_CHECKSUM_EN
                    sum_next       = '0;
                    csum_next      = 1'b0;
                    if (clamped_len == '0) begin
                        // empty transfer still emits the (zero) checksum byte
                        data_next  = '0;
                        csum_next  = 1'b1;
                        state_next = SEND;
                    end else begin
                        state_next = FETCH;
                    end
`else
                    state_next     = (clamped_len == '0) ? FINISH : FETCH;
`endif
                end
            end
            FETCH: begin
                state_next = LOAD;
            end
            LOAD: begin
                data_next  = rdata;
                raddr_next = raddr_reg + 1'b1;
`ifdef TRACE_CHECKSUM_EN
                sum_next   = sum_reg + rdata;
`endif
                state_next = SEND;
            end
            SEND: begin
                if (uart_tx_ready && !en_reg) begin
                    en_next    = 1'b1;
                    state_next = ACK;
`ifdef TRACE_CHECKSUM_EN
                    if (!csum_reg) begin
                        remaining_next = remaining_reg - 1'b1;
                    end
`else
                    remaining_next = remaining_reg - 1'b1;
`endif
                end
            end
            ACK: begin
                if (!uart_tx_ready) begin
                    if (remaining_reg == '0) begin
`ifdef TRACE_CHECKSUM_EN
                        if (!csum_reg) begin
                            data_next  = sum_reg;
                            csum_next  = 1'b1;
                            state_next = SEND;
                        end else begin
                            state_next = FINISH;
                        end
`else
                        state_next = FINISH;
`endif
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            FINISH: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy            = busy_reg;
    assign done            = done_reg;
    assign raddr           = raddr_reg;
    assign uart_tx_enable  = en_reg;
    assign uart_data_to_tx = data_reg;

endmodule

// File: tb/tb_trace_reader.sv
// Bench for trace_reader: BRAM and UART models, table vectors, corner sequences, random transfers.
module tb_trace_reader;

    localparam int MAXL  = 512;
    localparam int LIMIT = 10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [8:0] start_addr = '0;
    logic [9:0] length = '0;
    logic       busy;
    logic       done;
    logic [8:0] raddr;
    logic [7:0] rdata;
    logic       uart_tx_ready = 1'b1;
    logic       uart_tx_enable;
    logic [7:0] uart_data_to_tx;

    int vectors = 0;
    int miscompares = 0;

    trace_reader dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .start_addr(start_addr),
        .length(length),
        .busy(busy),
        .done(done),
        .raddr(raddr),
        .rdata(rdata),
        .uart_tx_ready(uart_tx_ready),
        .uart_tx_enable(uart_tx_enable),
        .uart_data_to_tx(uart_data_to_tx)
    );

    always #5 clk = ~clk;

    // BRAM model: registered read
    logic [7:0] mem [0:511];
    always @(posedge clk) rdata <= mem[raddr];

    // UART model: ready falls right after enable, returns 10 cycles later
    int low_cnt = 0;
    always @(negedge clk) begin
        if (uart_tx_enable) begin
            uart_tx_ready <= 1'b0;
            low_cnt       <= 10;
        end else if (low_cnt > 0) begin
            low_cnt <= low_cnt - 1;
            if (low_cnt == 1) uart_tx_ready <= 1'b1;
        end
    end

    // Monitor: captured bytes, done pulses, address trace, handshake violations
    logic [7:0] got_q [$];
    logic [8:0] trace_q [$];
    int  done_cnt = 0;
    int  proto_err = 0;
    bit  prev_en = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_en <= 1'b0;
        end else begin
            if (uart_tx_enable) begin
                got_q.push_back(uart_data_to_tx);
                if (!uart_tx_ready || prev_en) proto_err++;
            end
            prev_en <= uart_tx_enable;
            if (done) begin
                done_cnt++;
                if (busy) proto_err++;
            end
            if (busy && ((trace_q.size() == 0) || (trace_q[trace_q.size()-1] != raddr)))
                trace_q.push_back(raddr);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // mode 0: plain, 1: second start during byte 2, 2: start in the done cycle
    task automatic run_transfer(input logic [8:0] a, input logic [9:0] l, input int mode);
        logic [7:0] exp_q [$];
        int n, sum, cycles, late_busy, busy_cycles, m;
        bit injected;
        n = (int'(l) > MAXL) ? MAXL : int'(l);
        sum = 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[(int'(a) + i) % MAXL]);
            sum += int'(mem[(int'(a) + i) % MAXL]);
        end
`ifdef TRACE_CHECKSUM_EN
        exp_q.push_back(8'(sum % 256));
`endif
        got_q.delete();
        trace_q.delete();
        done_cnt = 0;
        proto_err = 0;
        busy_cycles = 0;
        injected = 1'b0;
        @(negedge clk); #1;
        start = 1'b1; start_addr = a; length = l;
        @(negedge clk); #1;
        start = 1'b0;
        if (busy) busy_cycles++;
        cycles = 0;
        while (!done && cycles < LIMIT) begin
            @(negedge clk); #1;
            cycles++;
            start = 1'b0;
            if (busy) busy_cycles++;
            if (mode == 1 && !injected && got_q.size() == 2) begin
                start = 1'b1; start_addr = 9'h100; length = 10'd8;
                injected = 1'b1;
            end
        end
        check("done_seen", {31'b0, done}, 1);
        if (mode == 2) begin
            start = 1'b1; start_addr = 9'h000; length = 10'd5;
        end
        late_busy = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (busy) late_busy++;
        end
        check("byte_count", got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) check("byte", {24'b0, got_q[i]}, {24'b0, exp_q[i]});
        check("done_count", done_cnt, 1);
        check("handshake", proto_err, 0);
        check("busy_after_done", late_busy, 0);
        check("raddr_trace_len", trace_q.size(), n + 1);
        m = (trace_q.size() < n + 1) ? trace_q.size() : n + 1;
        for (int i = 0; i < m; i++) check("raddr", {23'b0, trace_q[i]}, (int'(a) + i) % MAXL);
`ifndef TRACE_CHECKSUM_EN
        if (n == 0) check("busy_len0", {31'b0, busy_cycles <= 2}, 1);
`endif
    endtask

    typedef struct {
        logic [8:0] addr;
        logic [9:0] len;
        int         cnt;
        logic [7:0] first;
        logic [7:0] last;
    } vec_t;

    vec_t tbl [4];

    initial begin
`ifdef TRACE_CHECKSUM_EN
        tbl[0] = '{9'h000, 10'd56,  57,  8'h00, 8'h04};
        tbl[1] = '{9'h1FE, 10'd4,   5,   8'hFE, 8'hFE};
        tbl[2] = '{9'h055, 10'd0,   1,   8'h00, 8'h00};
        tbl[3] = '{9'h1F0, 10'd600, 513, 8'hF0, 8'h00};
`else
        tbl[0] = '{9'h000, 10'd56,  56,  8'h00, 8'h37};
        tbl[1] = '{9'h1FE, 10'd4,   4,   8'hFE, 8'h01};
        tbl[2] = '{9'h055, 10'd0,   0,   8'h00, 8'h00};
        tbl[3] = '{9'h1F0, 10'd600, 512, 8'hF0, 8'hEF};
`endif
        for (int i = 0; i < MAXL; i++) mem[i] = 8'(i);

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_raddr", {23'b0, raddr}, 0);
        check("rst_enable", {31'b0, uart_tx_enable}, 0);
        check("rst_data", {24'b0, uart_data_to_tx}, 0);
        rst = 1'b0;

        // table vectors
        for (int t = 0; t < 4; t++) begin
            run_transfer(tbl[t].addr, tbl[t].len, 0);
            check("tbl_count", got_q.size(), tbl[t].cnt);
            if (tbl[t].cnt > 0 && got_q.size() > 0) begin
                check("tbl_first", {24'b0, got_q[0]}, {24'b0, tbl[t].first});
                check("tbl_last", {24'b0, got_q[got_q.size()-1]}, {24'b0, tbl[t].last});
            end
        end

        // second start during a transfer is ignored
        run_transfer(9'h000, 10'd8, 1);
        // start in the done cycle is ignored
        run_transfer(9'h020, 10'd3, 2);

        // reset after the third enable of a length-20 transfer
        got_q.delete();
        done_cnt = 0;
        @(negedge clk); #1;
        start = 1'b1; start_addr = 9'h000; length = 10'd20;
        @(negedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < LIMIT && got_q.size() < 3; c++) begin
            @(negedge clk); #1;
        end
        check("mid_reach3", got_q.size(), 3);
        rst = 1'b1;
        @(negedge clk); #1;
        check("mid_rst_enable", {31'b0, uart_tx_enable}, 0);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_raddr", {23'b0, raddr}, 0);
        check("mid_rst_done", {31'b0, done}, 0);
        rst = 1'b0;
        got_q.delete();
        done_cnt = 0;
        repeat (30) @(negedge clk);
        #1;
        check("mid_no_enable", got_q.size(), 0);
        check("mid_no_done", done_cnt, 0);
        run_transfer(9'h010, 10'd2, 0);
        if (got_q.size() == 2) begin
            check("post_rst_b0", {24'b0, got_q[0]}, 32'h10);
            check("post_rst_b1", {24'b0, got_q[1]}, 32'h11);
        end

        // 80, 80, 01 pattern: checksum wraps to 0x01
        mem[0] = 8'h80; mem[1] = 8'h80; mem[2] = 8'h01;
        run_transfer(9'h000, 10'd3, 0);
`ifdef TRACE_CHECKSUM_EN
        check("sum_count", got_q.size(), 4);
`else
        check("sum_count", got_q.size(), 3);
`endif
        if (got_q.size() > 0) check("sum_last", {24'b0, got_q[got_q.size()-1]}, 32'h01);

        // randomized transfers against the reference model
        for (int i = 0; i < MAXL; i++) mem[i] = 8'($urandom);
        for (int it = 0; it < 20; it++) begin
            logic [8:0] ra;
            logic [9:0] rl;
            ra = 9'($urandom_range(0, 511));
            rl = (it == 0) ? 10'($urandom_range(513, 1023)) : 10'($urandom_range(0, 40));
            run_transfer(ra, rl, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
